// File: rtl/cla_sub_serial_pkg.sv
// Shared types and constants for the serial borrow-lookahead subtractor.
package cla_sub_serial_pkg;

    localparam int unsigned SLICE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/cla_sub_serial_slice4.sv
// 4-bit subtract slice with fully expanded two-level borrow lookahead.
module cla_sub_slice4
    import cla_sub_serial_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               bin,
    output logic [SLICE_W-1:0] d,
    output logic               bout
);

    logic [3:0] gb;
    logic [3:0] pb;
    logic [4:0] c;

    always_comb begin
        // gb: this bit borrows on its own; pb: equal bits pass an incoming borrow through
        gb   = ~a & b;
        pb   = ~(a ^ b);
        c[0] = bin;
        c[1] = gb[0] | (pb[0] & bin);
        c[2] = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & bin);
        c[3] = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0])
             | (pb[2] & pb[1] & pb[0] & bin);
        c[4] = gb[3] | (pb[3] & gb[2]) | (pb[3] & pb[2] & gb[1])
             | (pb[3] & pb[2] & pb[1] & gb[0])
             | (pb[3] & pb[2] & pb[1] & pb[0] & bin);
        d    = a ^ b ^ c[3:0];
        bout = c[4];
    end

endmodule

// File: rtl/cla_sub_serial.sv
// Multi-cycle a - b - bin, one 4-bit lookahead slice per clock, with start/busy/done handshake.
module cla_sub_serial
    import cla_sub_serial_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);

    localparam int unsigned NSLICE = WIDTH / SLICE_W;
    localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             brw_q, brw_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    logic [SLICE_W-1:0] sl_a, sl_b, sl_d;
    logic               sl_bout;

    cla_sub_slice4 u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .bin  (brw_q),
        .d    (sl_d),
        .bout (sl_bout)
    );

    always_comb begin
        sl_a = a_q[SLICE_W*cnt_q +: SLICE_W];
        sl_b = b_q[SLICE_W*cnt_q +: SLICE_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
            ST_RUN:           if (cnt_q == LAST) state_d = ST_DONE;
            default:          state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_RUN);
        done = (state_q == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            brw_q  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            brw_q  <= brw_d;
            a_q    <= a_d;
            b_q    <= b_d;
            diff_q <= diff_d;
            bout_q <= bout_d;
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        brw_d  = brw_q;
        a_d    = a_q;
        b_d    = b_q;
        diff_d = diff_q;
        bout_d = bout_q;
        zero_d = zero_q;
        ovf_d  = ovf_q;
        if (state_q != ST_RUN && start) begin
            a_d    = a;
            b_d    = b;
            brw_d  = bin;
            cnt_d  = '0;
            diff_d = '0;
            bout_d = 1'b0;
            zero_d = 1'b0;
            ovf_d  = 1'b0;
        end else if (state_q == ST_RUN) begin
            diff_d[SLICE_W*cnt_q +: SLICE_W] = sl_d;
            brw_d = sl_bout;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                // Flags use the diff including the slice written this edge
                cnt_d  = '0;
                bout_d = sl_bout;
                zero_d = (diff_d == '0);
                ovf_d  = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (diff_d[WIDTH-1] ^ a_q[WIDTH-1]);
            end
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;
    assign zero = zero_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_cla_sub_serial.sv
// Randomized and directed bench for cla_sub_serial against an arithmetic reference model.
module tb_cla_sub_serial;

    localparam int unsigned W = 16;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bout;
        logic         zero;
        logic         ovf;
    } res_t;

    logic         clk, rst_n, start, bin;
    logic [W-1:0] a, b;
    logic         busy, done, bout, zero, ovf;
    logic [W-1:0] diff;

    int checks = 0;
    int passes = 0;

    cla_sub_serial #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .zero  (zero),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL global_timeout: got no finish, want finish within 1ms");
        $fatal(1, "timeout");
    end

    function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
        res_t r;
        int   ud;
        int   sd;
        ud     = int'(ma) - int'(mb) - int'(mbin);
        sd     = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
        r.diff = ud[W-1:0];
        r.bout = (ud < 0);
        r.zero = (r.diff == '0);
        r.ovf  = (sd > 32767) || (sd < -32768);
        return r;
    endfunction

    // Starts one operation from the current (non-RUN) state and waits for done.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                         output int cyc, output logic acc_ok);
        @(negedge clk);
        a = ta; b = tb; bin = tbin; start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        acc_ok = (busy === 1'b1) && (done === 1'b0);
        a   = W'($urandom);
        b   = W'($urandom);
        bin = 1'($urandom_range(0, 1));
        cyc = -1;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                cyc = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if ({busy, done, diff, bout, zero, ovf} !== '0)
            $display("FAIL reset_state: got busy=%b done=%b diff=%h bout=%b zero=%b ovf=%b want all 0",
                     busy, done, diff, bout, zero, ovf);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [W-1:0] va [4] = '{16'h1234, 16'h0000, 16'h8000, 16'h8000};
        logic [W-1:0] vb [4] = '{16'h0234, 16'h0001, 16'h0001, 16'h0000};
        logic         vc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        res_t         ve [4] = '{'{16'h1000, 1'b0, 1'b0, 1'b0},
                                 '{16'hFFFF, 1'b1, 1'b0, 1'b0},
                                 '{16'h7FFF, 1'b0, 1'b0, 1'b1},
                                 '{16'h7FFF, 1'b0, 1'b0, 1'b1}};
        int   cyc;
        logic acc_ok;
        for (int i = 0; i < 4; i++) begin
            do_op(va[i], vb[i], vc[i], cyc, acc_ok);
            checks++;
            if (cyc != 4) $display("FAIL basic_latency[%0d]: got %0d want 4", i, cyc);
            else passes++;
            checks++;
            if ({diff, bout, zero, ovf} !== ve[i])
                $display("FAIL basic_result[%0d]: got %h want %h", i, {diff, bout, zero, ovf}, ve[i]);
            else passes++;
            @(posedge clk);
            #1;
            checks++;
            if ({busy, done, diff, bout, zero, ovf} !== {2'b00, ve[i]})
                $display("FAIL basic_hold[%0d]: got busy=%b done=%b res=%h want busy=0 done=0 res=%h",
                         i, busy, done, {diff, bout, zero, ovf}, ve[i]);
            else passes++;
        end
    endtask

    task automatic test_back_to_back();
        int   cyc;
        logic acc_ok;
        do_op(16'h5555, 16'h5555, 1'b0, cyc, acc_ok);
        checks++;
        if (cyc != 4 || {diff, bout, zero, ovf} !== {16'h0000, 1'b0, 1'b1, 1'b0})
            $display("FAIL b2b_first: got cyc=%0d res=%h want cyc=4 res=%h",
                     cyc, {diff, bout, zero, ovf}, {16'h0000, 3'b010});
        else passes++;
        do_op(16'h0001, 16'h0000, 1'b1, cyc, acc_ok);
        checks++;
        if (acc_ok !== 1'b1) $display("FAIL b2b_accept: got accept_ok=%b want 1", acc_ok);
        else passes++;
        checks++;
        if (cyc != 4 || {diff, bout, zero, ovf} !== {16'h0000, 1'b0, 1'b1, 1'b0})
            $display("FAIL b2b_second: got cyc=%0d res=%h want cyc=4 res=%h",
                     cyc, {diff, bout, zero, ovf}, {16'h0000, 3'b010});
        else passes++;
        @(posedge clk);
    endtask

    task automatic test_start_while_busy();
        int   pulses = 0;
        int   first = -1;
        res_t at_done = '0;
        res_t exp = '{16'h1DCC, 1'b0, 1'b0, 1'b0};
        @(negedge clk);
        a = 16'h3000; b = 16'h1234; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk);
            #1;
            if (n == 2) begin
                start = 1'b1; a = 16'hFFFF; b = 16'h0000; bin = 1'b0;
            end else if (n == 3) begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                pulses++;
                if (first < 0) begin
                    first   = n;
                    at_done = {diff, bout, zero, ovf};
                end
            end
        end
        checks++;
        if (pulses != 1 || first != 4)
            $display("FAIL busy_start_pulses: got pulses=%0d first=%0d want pulses=1 first=4", pulses, first);
        else passes++;
        checks++;
        if (at_done !== exp) $display("FAIL busy_start_result: got %h want %h", at_done, exp);
        else passes++;
    endtask

    task automatic test_reset_mid_op();
        int   cyc;
        logic acc_ok;
        logic saw_done = 1'b0;
        @(negedge clk);
        a = 16'h1237; b = 16'h0001; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, diff, bout, zero, ovf} !== '0)
            $display("FAIL midop_reset: got busy=%b done=%b diff=%h bout=%b zero=%b ovf=%b want all 0",
                     busy, done, diff, bout, zero, ovf);
        else passes++;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) $display("FAIL midop_no_done: got activity=%b want 0", saw_done);
        else passes++;
        do_op(16'h0100, 16'h0001, 1'b0, cyc, acc_ok);
        checks++;
        if (cyc != 4 || {diff, bout, zero, ovf} !== {16'h00FF, 3'b000})
            $display("FAIL midop_fresh: got cyc=%0d res=%h want cyc=4 res=%h",
                     cyc, {diff, bout, zero, ovf}, {16'h00FF, 3'b000});
        else passes++;
        @(posedge clk);
    endtask

    task automatic test_random();
        int           cyc;
        logic         acc_ok;
        logic [W-1:0] ra, rb;
        logic         rc;
        res_t         exp;
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: rb = ra;
                1: ra = {1'b1, 15'($urandom_range(0, 3))};
                2: rb = {1'b0, 15'h7FFF - 15'($urandom_range(0, 3))};
                default: ;
            endcase
            exp = model(ra, rb, rc);
            for (int g = $urandom_range(0, 2); g > 0; g--) @(posedge clk);
            do_op(ra, rb, rc, cyc, acc_ok);
            checks++;
            if (acc_ok !== 1'b1 || cyc != 4)
                $display("FAIL rand_handshake[%0d]: got accept_ok=%b cyc=%0d want 1 and 4", i, acc_ok, cyc);
            else passes++;
            checks++;
            if ({diff, bout, zero, ovf} !== exp)
                $display("FAIL rand_result[%0d]: a=%h b=%h bin=%b got %h want %h",
                         i, ra, rb, rc, {diff, bout, zero, ovf}, exp);
            else passes++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_start_while_busy();
        test_reset_mid_op();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
